// File: rtl/instr_encoder_loader_if.sv
// Field/handshake bundle between an instruction source and the encoder-loader,
// plus the instruction-memory write port the loader drives.
interface instr_encoder_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              done;
   logic              err;

   modport master (
      output start, in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, last,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, done, err
   );

   modport slave (
      input  start, in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, last,
      output in_ready, imem_we, imem_addr, imem_wdata, count, done, err
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes decoded MIPS instruction descriptions into 32-bit words and writes them
// to consecutive instruction-memory locations, one word per two cycles.
module instr_encoder_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input logic                   clk,
   input logic                   rst,
   instr_encoder_loader_if.slave bus
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(Depth - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              last_q, last_d;
   logic              err_q, err_d;

   logic              legal;
   logic [31:0]       enc;

   always_comb begin
      legal = 1'b1;
      enc   = '0;
      case (bus.op_sel)
         4'd0:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         4'd1:    enc = {6'b100011, bus.rs, bus.rt, bus.imm};
         4'd2:    enc = {6'b101011, bus.rs, bus.rt, bus.imm};
         4'd3:    enc = {6'b000100, bus.rs, bus.rt, bus.imm};
         4'd4:    enc = {6'b000101, bus.rs, bus.rt, bus.imm};
         4'd5:    enc = {6'b000010, bus.target};
         4'd6:    enc = {6'b001000, bus.rs, bus.rt, bus.imm};
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StLoad;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         StLoad: begin
            if (bus.in_valid) begin
               if (legal) begin
                  wdata_d = enc;
                  addr_d  = count_q[ADDR_W-1:0];
                  last_d  = bus.last;
                  state_d = StWrite;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StWrite: begin
            count_d = count_q + 1'b1;
            // A last-flagged final slot ends cleanly; only an unflagged full memory is an error.
            if (last_q) begin
               state_d = StDone;
            end else if (count_q == LastPtr) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         count_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready   = (state_q == StLoad);
   assign bus.imem_we    = (state_q == StWrite);
   assign bus.done       = (state_q == StDone);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a vector table streamed through an 8-bit-address instance, plus
// hand sequences for gaps, illegal ops, mid-write reset and a 4-word capacity instance.
module tb_instr_encoder_loader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   instr_encoder_loader_if #(.ADDR_W(8)) m ();
   instr_encoder_loader_if #(.ADDR_W(2)) s ();

   instr_encoder_loader #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(m));
   instr_encoder_loader #(.ADDR_W(2)) dut_small (.clk(clk), .rst(rst), .bus(s));

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
      logic        last;
      logic [31:0] word;
   } vec_t;

   vec_t tbl [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      m.op_sel = v.op;
      m.rs     = v.rs;
      m.rt     = v.rt;
      m.rd     = v.rd;
      m.shamt  = v.shamt;
      m.funct  = v.funct;
      m.imm    = v.imm;
      m.target = v.target;
      m.last   = v.last;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!m.in_ready && n < 10) begin
         step();
         n++;
      end
      chk("ready_timeout", 32'(m.in_ready), 32'd1);
   endtask

   task automatic start_main();
      m.start = 1'b1;
      step();
      m.start = 1'b0;
   endtask

   task automatic start_small();
      s.start = 1'b1;
      step();
      s.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //       op    rs     rt     rd    sh    funct   imm        target     last  word
      tbl[0] = '{4'd6, 5'd0,  5'd8,  5'd0, 5'd0, 6'h00, 16'h0005, 26'h0,     1'b0, 32'h20080005};
      tbl[1] = '{4'd0, 5'd9,  5'd10, 5'd8, 5'd0, 6'h20, 16'h0000, 26'h0,     1'b0, 32'h012A4020};
      tbl[2] = '{4'd1, 5'd29, 5'd8,  5'd0, 5'd0, 6'h00, 16'h0004, 26'h0,     1'b0, 32'h8FA80004};
      tbl[3] = '{4'd2, 5'd29, 5'd9,  5'd0, 5'd0, 6'h00, 16'h0008, 26'h0,     1'b0, 32'hAFA90008};
      tbl[4] = '{4'd3, 5'd8,  5'd9,  5'd0, 5'd0, 6'h00, 16'hFFFD, 26'h0,     1'b0, 32'h1109FFFD};
      tbl[5] = '{4'd4, 5'd8,  5'd9,  5'd0, 5'd0, 6'h00, 16'hFFFD, 26'h0,     1'b0, 32'h1509FFFD};
      tbl[6] = '{4'd5, 5'd3,  5'd4,  5'd5, 5'd6, 6'h3F, 16'h1234, 26'h10,    1'b1, 32'h08000010};

      m.start = 0; m.in_valid = 0; m.op_sel = 0; m.rs = 0; m.rt = 0; m.rd = 0;
      m.shamt = 0; m.funct = 0; m.imm = 0; m.target = 0; m.last = 0;
      s.start = 0; s.in_valid = 0; s.op_sel = 0; s.rs = 0; s.rt = 0; s.rd = 0;
      s.shamt = 0; s.funct = 0; s.imm = 0; s.target = 0; s.last = 0;

      rst = 1'b0;
      step();
      step();
      chk("rst_in_ready", 32'(m.in_ready), 32'd0);
      chk("rst_we", 32'(m.imem_we), 32'd0);
      chk("rst_addr", 32'(m.imem_addr), 32'd0);
      chk("rst_wdata", m.imem_wdata, 32'd0);
      chk("rst_count", 32'(m.count), 32'd0);
      chk("rst_done", 32'(m.done), 32'd0);
      chk("rst_err", 32'(m.err), 32'd0);
      rst = 1'b1;
      step();
      chk("idle_no_ready", 32'(m.in_ready), 32'd0);

      // Table stream with in_valid held high: one accept every two cycles.
      start_main();
      for (int i = 0; i < 7; i++) begin
         apply(tbl[i]);
         m.in_valid = 1'b1;
         wait_ready();
         step();
         chk($sformatf("v%0d_we", i), 32'(m.imem_we), 32'd1);
         chk($sformatf("v%0d_addr", i), 32'(m.imem_addr), 32'(i));
         chk($sformatf("v%0d_wdata", i), m.imem_wdata, tbl[i].word);
         chk($sformatf("v%0d_ready_low", i), 32'(m.in_ready), 32'd0);
         step();
         chk($sformatf("v%0d_we_off", i), 32'(m.imem_we), 32'd0);
         chk($sformatf("v%0d_count", i), 32'(m.count), 32'(i + 1));
         if (i < 6) chk($sformatf("v%0d_ready_again", i), 32'(m.in_ready), 32'd1);
      end
      m.in_valid = 1'b0;
      chk("stream_done", 32'(m.done), 32'd1);
      chk("stream_err", 32'(m.err), 32'd0);
      chk("stream_ready", 32'(m.in_ready), 32'd0);
      step();
      chk("done_sticky", 32'(m.done), 32'd1);
      chk("done_we", 32'(m.imem_we), 32'd0);

      // Restart, idle gap in LOAD, one legal write, then an illegal op.
      start_main();
      chk("restart_count", 32'(m.count), 32'd0);
      chk("restart_done", 32'(m.done), 32'd0);
      for (int g = 0; g < 3; g++) begin
         step();
         chk("gap_we", 32'(m.imem_we), 32'd0);
         chk("gap_ready", 32'(m.in_ready), 32'd1);
         chk("gap_addr", 32'(m.imem_addr), 32'd6);
         chk("gap_wdata", m.imem_wdata, 32'h08000010);
      end
      apply(tbl[0]);
      m.in_valid = 1'b1;
      step();
      chk("g_write_addr", 32'(m.imem_addr), 32'd0);
      chk("g_write_wdata", m.imem_wdata, 32'h20080005);
      step();
      m.op_sel = 4'd9;
      step();
      m.in_valid = 1'b0;
      chk("ill_we", 32'(m.imem_we), 32'd0);
      chk("ill_err", 32'(m.err), 32'd1);
      chk("ill_done", 32'(m.done), 32'd1);
      chk("ill_count", 32'(m.count), 32'd1);
      chk("ill_ready", 32'(m.in_ready), 32'd0);
      chk("ill_wdata_held", m.imem_wdata, 32'h20080005);
      step();
      chk("ill_err_sticky", 32'(m.err), 32'd1);

      // Reset during a WRITE cycle aborts it; next session restarts at address 0.
      start_main();
      chk("restart_err_clr", 32'(m.err), 32'd0);
      apply(tbl[1]);
      m.in_valid = 1'b1;
      step();
      chk("mid_we", 32'(m.imem_we), 32'd1);
      m.in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("mid_rst_we", 32'(m.imem_we), 32'd0);
      chk("mid_rst_addr", 32'(m.imem_addr), 32'd0);
      chk("mid_rst_wdata", m.imem_wdata, 32'd0);
      chk("mid_rst_count", 32'(m.count), 32'd0);
      chk("mid_rst_ready", 32'(m.in_ready), 32'd0);
      chk("mid_rst_done", 32'(m.done), 32'd0);
      chk("mid_rst_err", 32'(m.err), 32'd0);
      rst = 1'b1;
      step();
      start_main();
      apply(tbl[3]);
      m.in_valid = 1'b1;
      step();
      m.in_valid = 1'b0;
      chk("resume_we", 32'(m.imem_we), 32'd1);
      chk("resume_addr", 32'(m.imem_addr), 32'd0);
      chk("resume_wdata", m.imem_wdata, 32'hAFA90008);
      step();
      chk("resume_count", 32'(m.count), 32'd1);

      // Four-word memory: five offers without last overflow after the fourth write.
      start_small();
      s.op_sel   = 4'd6;
      s.last     = 1'b0;
      s.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s.rt  = 5'(k);
         s.imm = 16'(k + 1);
         step();
         chk($sformatf("ov%0d_we", k), 32'(s.imem_we), 32'd1);
         chk($sformatf("ov%0d_addr", k), 32'(s.imem_addr), 32'(k));
         chk($sformatf("ov%0d_wdata", k), s.imem_wdata,
             32'h2000_0000 | (32'(k) << 16) | 32'(k + 1));
         step();
      end
      chk("ov_done", 32'(s.done), 32'd1);
      chk("ov_err", 32'(s.err), 32'd1);
      chk("ov_count", 32'(s.count), 32'd4);
      chk("ov_ready", 32'(s.in_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("ov_fifth_we", 32'(s.imem_we), 32'd0);
         chk("ov_fifth_count", 32'(s.count), 32'd4);
      end
      s.in_valid = 1'b0;

      // Four-word memory filled exactly with last on the final word ends cleanly.
      start_small();
      s.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s.last = (k == 3);
         s.rt   = 5'(k + 4);
         step();
         chk($sformatf("full%0d_addr", k), 32'(s.imem_addr), 32'(k));
         step();
      end
      s.in_valid = 1'b0;
      chk("full_done", 32'(s.done), 32'd1);
      chk("full_err", 32'(s.err), 32'd0);
      chk("full_count", 32'(s.count), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the main control decoder. Accepts decoded instruction descriptions (operation class plus register, immediate and target fields) over a valid/ready handshake. Encodes each one into a 32-bit MIPS word and writes it into consecutive instruction-memory locations. Used by the testbench and boot path to preload the single-cycle core's instruction memory with the supported subset: R-type, lw, sw, beq, bne, j, addi.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets the block)
start  input  1  begin a new load session; honoured only in IDLE or DONE
in_valid  input  1  instruction fields valid
in_ready  output  1  block can accept fields this cycle
op_sel  input  4  0=R-type, 1=lw, 2=sw, 3=beq, 4=bne, 5=j, 6=addi, 7..15 illegal
rs, rt, rd, shamt  input  5 each  register and shift fields
funct  input  6  R-type function code
imm  input  16  immediate / branch word offset, passed unchanged
target  input  26  jump target field
last  input  1  this is the final instruction of the session
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  encoded instruction word
count  output  ADDR_W+1  words written this session
done  output  1  session finished (sticky until start or reset)
err  output  1  illegal op_sel or capacity overflow (sticky until start or reset)

Behaviour:
- States: IDLE, LOAD, WRITE, DONE. FSM is registered. in_ready = (state==LOAD), decoded from the state register only; there is no combinational path from in_valid.
- Reset (rst==0 at an edge, any state, including mid-WRITE): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0. A write in progress is aborted.
- IDLE: waits for start=1, then goes to LOAD with ptr=0, count=0, done=0, err=0.
- LOAD: a transfer occurs when in_valid && in_ready at an edge.
  - Legal op_sel: the encoded word is registered into imem_wdata, imem_addr=ptr, imem_we=1, last is captured, and the FSM goes to WRITE.
  - Illegal op_sel: no write, err=1, and the FSM goes to DONE.
  - in_valid=0: the FSM stays in LOAD with all outputs held.
- Encoding (fields not used by the opcode are ignored):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - bne: {6'b000101, rs, rt, imm}
  - addi: {6'b001000, rs, rt, imm}
  - j: {6'b000010, target}
- WRITE: imem_we=1 for exactly this one cycle; in_ready=0. At the edge: imem_we goes to 0, ptr+1, count+1. Next state:
  - captured last=1: DONE, err unchanged.
  - else if ptr was DEPTH-1 (memory full): DONE with err=1.
  - else: LOAD.
- Throughput is one instruction per 2 cycles. The write occurs in the cycle immediately after the accepting edge.
- Writing the DEPTH-th word with last=1 ends normally (err=0). ptr never wraps.
- DONE: done=1, in_ready=0, imem_we=0. imem_addr and imem_wdata hold their last values. start returns to LOAD, clearing ptr, count, done and err.
- start is ignored in LOAD and WRITE.
- count saturates naturally at DEPTH; no other arithmetic is performed.

Test Plan:
- Reset, start, in_valid with op_sel=6, rs=0, rt=8, imm=0x0005, last=0 -> next cycle imem_we=1 for 1 cycle, imem_addr=0, imem_wdata=0x20080005; count=1; in_ready=1 again one cycle later.
- Stream, last on the final entry:
  - R-type rs=9, rt=10, rd=8, shamt=0, funct=0x20 -> 0x012A4020 @1
  - lw rs=29, rt=8, imm=4 -> 0x8FA80004 @2
  - sw rs=29, rt=9, imm=8 -> 0xAFA90008 @3
  - beq rs=8, rt=9, imm=0xFFFD -> 0x1109FFFD @4
  - bne same fields -> 0x1509FFFD @5
  - j target=0x10, last=1 -> 0x08000010 @6
  - Then done=1, err=0, count=7.
- op_sel=9 offered in LOAD -> no imem_we pulse, err=1, done=1, count unchanged, in_ready=0.
- ADDR_W=2, 5 instructions offered with last=0 -> writes at addr 0..3 only, then done=1, err=1, count=4; the 5th is never accepted.
- in_valid held high continuously -> exactly one accept every 2 cycles. A 3-cycle in_valid=0 gap in LOAD -> no writes, outputs held.
- rst=0 asserted during a WRITE cycle -> at the next edge imem_we=0 and all outputs at reset values. A subsequent start resumes writing from addr 0.
